// File: rtl/vga_mode_sequencer_pkg.sv
// Shared constants for the VGA mode sequencer: mode indices, the 60 Hz timing table and
// the controller state encoding.
package vga_mode_sequencer_pkg;

  localparam logic [1:0] Mode640  = 2'd0;
  localparam logic [1:0] Mode800  = 2'd1;
  localparam logic [1:0] Mode1024 = 2'd2;
  localparam logic [1:0] Mode1280 = 2'd3;

  typedef struct packed {
    int unsigned h_total;
    int unsigned h_sync;
    int unsigned h_start;
    int unsigned h_active;
    int unsigned v_total;
    int unsigned v_sync;
    int unsigned v_start;
    int unsigned v_active;
  } mode_timing_t;

  typedef enum logic {
    StLoad = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Start is sync + back porch, so start + active never exceeds total.
  function automatic mode_timing_t mode_timing(input logic [1:0] mode);
    mode_timing_t t;
    unique case (mode)
      Mode640:  t = '{800,  96,  144, 640,  525,  2, 35, 480};
      Mode800:  t = '{1056, 128, 216, 800,  628,  4, 27, 600};
      Mode1024: t = '{1344, 136, 296, 1024, 806,  6, 35, 768};
      Mode1280: t = '{1688, 112, 360, 1280, 1066, 3, 41, 1024};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/vga_mode_rom.sv
// Combinational mode table: 2-bit mode index to the eight timing fields.
module vga_mode_rom
  import vga_mode_sequencer_pkg::*;
#(
  parameter int unsigned REZ_MAX_WIDTH = 11,
  parameter int unsigned PULSE_WIDTH   = 8
) (
  input  logic [1:0]               mode_i,
  output logic [REZ_MAX_WIDTH-1:0] h_count_max_o,
  output logic [PULSE_WIDTH-1:0]   h_sync_o,
  output logic [REZ_MAX_WIDTH-1:0] h_start_o,
  output logic [REZ_MAX_WIDTH-1:0] h_active_o,
  output logic [REZ_MAX_WIDTH-1:0] v_count_max_o,
  output logic [PULSE_WIDTH-1:0]   v_sync_o,
  output logic [REZ_MAX_WIDTH-1:0] v_start_o,
  output logic [REZ_MAX_WIDTH-1:0] v_active_o
);

  mode_timing_t t;

  always_comb begin
    t             = mode_timing(mode_i);
    h_count_max_o = REZ_MAX_WIDTH'(t.h_total - 1);
    h_sync_o      = PULSE_WIDTH'(t.h_sync);
    h_start_o     = REZ_MAX_WIDTH'(t.h_start);
    h_active_o    = REZ_MAX_WIDTH'(t.h_active);
    v_count_max_o = REZ_MAX_WIDTH'(t.v_total - 1);
    v_sync_o      = PULSE_WIDTH'(t.v_sync);
    v_start_o     = REZ_MAX_WIDTH'(t.v_start);
    v_active_o    = REZ_MAX_WIDTH'(t.v_active);
  end

endmodule

// File: rtl/vga_mode_sequencer.sv
// VGA timing controller: mode table, frame-boundary mode switching with a settle window and
// registered Video_on. Define VGA_SEQ_FRAME_CNT_EN to add the Frame_count output.
module vga_mode_sequencer
  import vga_mode_sequencer_pkg::*;
#(
  parameter int unsigned REZ_MAX_WIDTH = 11,
  parameter int unsigned PULSE_WIDTH   = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [1:0]  DEFAULT_MODE  = Mode640
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Cfg_valid,
  input  logic [1:0]               Cfg_mode,
  output logic                     Cfg_ready,
  input  logic [REZ_MAX_WIDTH-1:0] H_count,
  input  logic [REZ_MAX_WIDTH-1:0] V_count,
  output logic [PULSE_WIDTH-1:0]   H_sync_pulse,
  output logic [REZ_MAX_WIDTH-1:0] H_count_max,
  output logic [PULSE_WIDTH-1:0]   V_sync_pulse,
  output logic [REZ_MAX_WIDTH-1:0] V_count_max,
  output logic                     Counter_rst,
  output logic                     Video_on,
  output logic [1:0]               Mode_active,
  output logic                     Busy
`ifdef VGA_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]              Frame_count
`endif
);

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  state_e state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic pending_q, pending_d;
  logic [1:0] pend_mode_q, pend_mode_d;
  logic [1:0] mode_q, mode_d;
  logic video_on_q, video_on_d;

  logic [REZ_MAX_WIDTH-1:0] h_max_q, h_start_q, h_active_q, v_max_q, v_start_q, v_active_q;
  logic [PULSE_WIDTH-1:0] h_sync_q, v_sync_q;
  logic [REZ_MAX_WIDTH-1:0] h_max_d, h_start_d, h_active_d, v_max_d, v_start_d, v_active_d;
  logic [PULSE_WIDTH-1:0] h_sync_d, v_sync_d;

  logic [1:0] rom_mode;
  logic frame_end, handshake, h_in, v_in;
  logic [REZ_MAX_WIDTH:0] h_end, v_end;

  // Table is addressed by the next mode so parameters change together with Mode_active.
  assign rom_mode = Rst ? DEFAULT_MODE : mode_d;

  vga_mode_rom #(
    .REZ_MAX_WIDTH(REZ_MAX_WIDTH),
    .PULSE_WIDTH  (PULSE_WIDTH)
  ) u_rom (
    .mode_i       (rom_mode),
    .h_count_max_o(h_max_d),
    .h_sync_o     (h_sync_d),
    .h_start_o    (h_start_d),
    .h_active_o   (h_active_d),
    .v_count_max_o(v_max_d),
    .v_sync_o     (v_sync_d),
    .v_start_o    (v_start_d),
    .v_active_o   (v_active_d)
  );

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    pending_d   = pending_q;
    pend_mode_d = pend_mode_q;
    mode_d      = mode_q;
    Cfg_ready   = (state_q == StRun) && !pending_q;
    handshake   = Cfg_valid && Cfg_ready;
    frame_end   = (state_q == StRun) && (H_count == h_max_q) && (V_count == v_max_q);
    case (state_q)
      StLoad: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == SettleLast) state_d = StRun;
      end
      StRun: begin
        if (handshake && (Cfg_mode != mode_q)) begin
          pending_d   = 1'b1;
          pend_mode_d = Cfg_mode;
        end
        if (frame_end && pending_q) begin
          mode_d    = pend_mode_q;
          pending_d = 1'b0;
          settle_d  = 8'd0;
          state_d   = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase

    h_end      = {1'b0, h_start_q} + {1'b0, h_active_q};
    v_end      = {1'b0, v_start_q} + {1'b0, v_active_q};
    h_in       = (H_count >= h_start_q) && ({1'b0, H_count} < h_end);
    v_in       = (V_count >= v_start_q) && ({1'b0, V_count} < v_end);
    video_on_d = (state_d == StRun) && h_in && v_in;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StLoad;
      settle_q    <= 8'd0;
      pending_q   <= 1'b0;
      pend_mode_q <= DEFAULT_MODE;
      mode_q      <= DEFAULT_MODE;
      video_on_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      pending_q   <= pending_d;
      pend_mode_q <= pend_mode_d;
      mode_q      <= mode_d;
      video_on_q  <= video_on_d;
    end
  end

  always_ff @(posedge Clk) begin
    h_max_q    <= h_max_d;
    h_sync_q   <= h_sync_d;
    h_start_q  <= h_start_d;
    h_active_q <= h_active_d;
    v_max_q    <= v_max_d;
    v_sync_q   <= v_sync_d;
    v_start_q  <= v_start_d;
    v_active_q <= v_active_d;
  end

`ifdef VGA_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;
    if ((state_q == StRun) && (state_d == StLoad)) frame_cnt_d = 16'd0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) frame_cnt_q <= 16'd0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign Frame_count = frame_cnt_q;
`endif

  assign H_count_max  = h_max_q;
  assign H_sync_pulse = h_sync_q;
  assign V_count_max  = v_max_q;
  assign V_sync_pulse = v_sync_q;
  assign Counter_rst  = (state_q == StLoad);
  assign Video_on     = video_on_q;
  assign Mode_active  = mode_q;
  assign Busy         = (state_q == StLoad) || pending_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Directed testbench for vga_mode_sequencer with hand-computed expectations.
module tb_vga_mode_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Cfg_valid;
  logic [1:0]  Cfg_mode;
  logic        Cfg_ready;
  logic [10:0] H_count, V_count;
  logic [7:0]  H_sync_pulse, V_sync_pulse;
  logic [10:0] H_count_max, V_count_max;
  logic        Counter_rst, Video_on, Busy;
  logic [1:0]  Mode_active;
`ifdef VGA_SEQ_FRAME_CNT_EN
  logic [15:0] Frame_count;
`endif

  int checks = 0;
  int errors = 0;

  vga_mode_sequencer dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Cfg_valid   (Cfg_valid),
    .Cfg_mode    (Cfg_mode),
    .Cfg_ready   (Cfg_ready),
    .H_count     (H_count),
    .V_count     (V_count),
    .H_sync_pulse(H_sync_pulse),
    .H_count_max (H_count_max),
    .V_sync_pulse(V_sync_pulse),
    .V_count_max (V_count_max),
    .Counter_rst (Counter_rst),
    .Video_on    (Video_on),
    .Mode_active (Mode_active),
    .Busy        (Busy)
`ifdef VGA_SEQ_FRAME_CNT_EN
    ,
    .Frame_count (Frame_count)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Counts consecutive cycles with Counter_rst high, starting with the current one.
  task automatic count_rst(output int n);
    n = 0;
    while (Counter_rst === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic apply_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    apply_reset();
    checks++;
    if (H_count_max !== 11'd799 || V_count_max !== 11'd524) begin
      errors++;
      $display("FAIL reset_max: got %0d/%0d want 799/524", H_count_max, V_count_max);
    end
    checks++;
    if (H_sync_pulse !== 8'd96 || V_sync_pulse !== 8'd2) begin
      errors++;
      $display("FAIL reset_sync: got %0d/%0d want 96/2", H_sync_pulse, V_sync_pulse);
    end
    checks++;
    if ({Counter_rst, Video_on, Cfg_ready, Busy, Mode_active} !== 6'b1001_00) begin
      errors++;
      $display("FAIL reset_flags: got rst=%b von=%b rdy=%b busy=%b mode=%0d want 1 0 0 1 0",
               Counter_rst, Video_on, Cfg_ready, Busy, Mode_active);
    end
    count_rst(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL reset_settle_len: got %0d want 16", n);
    end
    checks++;
    if (Cfg_ready !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_run_ready: got rdy=%b busy=%b want 1 0", Cfg_ready, Busy);
    end
  endtask

  task automatic test_same_mode();
    Cfg_valid = 1'b1;
    Cfg_mode  = 2'd0;
    tick();
    Cfg_valid = 1'b0;
    checks++;
    if (Cfg_ready !== 1'b1 || Busy !== 1'b0 || Counter_rst !== 1'b0) begin
      errors++;
      $display("FAIL same_mode_accept: got rdy=%b busy=%b crst=%b want 1 0 0",
               Cfg_ready, Busy, Counter_rst);
    end
    H_count = 11'd799;
    V_count = 11'd524;
    tick();
    H_count = 11'd0;
    V_count = 11'd0;
    checks++;
    if (Counter_rst !== 1'b0 || Cfg_ready !== 1'b1 || Mode_active !== 2'd0) begin
      errors++;
      $display("FAIL same_mode_no_load: got crst=%b rdy=%b mode=%0d want 0 1 0",
               Counter_rst, Cfg_ready, Mode_active);
    end
  endtask

  task automatic test_video();
    logic [10:0] hv [6];
    logic [10:0] vv [6];
    logic        ev [6];
    hv = '{11'd143, 11'd144, 11'd783, 11'd784, 11'd144, 11'd900};
    vv = '{11'd35,  11'd35,  11'd514, 11'd514, 11'd515, 11'd524};
    ev = '{1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b0};
    for (int i = 0; i < 6; i++) begin
      H_count = hv[i];
      V_count = vv[i];
      tick();
      checks++;
      if (Video_on !== ev[i]) begin
        errors++;
        $display("FAIL video_on(%0d,%0d): got %b want %b", hv[i], vv[i], Video_on, ev[i]);
      end
    end
    H_count = 11'd0;
    V_count = 11'd0;
    checks++;
    if (Counter_rst !== 1'b0) begin
      errors++;
      $display("FAIL video_out_of_range_frame_end: got crst=%b want 0", Counter_rst);
    end
  endtask

  task automatic test_mode_change();
    int n;
    H_count   = 11'd100;
    V_count   = 11'd200;
    Cfg_valid = 1'b1;
    Cfg_mode  = 2'd2;
    tick();
    Cfg_valid = 1'b0;
    checks++;
    if (Cfg_ready !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL change_pending: got rdy=%b busy=%b want 0 1", Cfg_ready, Busy);
    end
    H_count = 11'd500;
    tick();
    tick();
    checks++;
    if (H_count_max !== 11'd799 || Counter_rst !== 1'b0 || Mode_active !== 2'd0) begin
      errors++;
      $display("FAIL change_hold: got max=%0d crst=%b mode=%0d want 799 0 0",
               H_count_max, Counter_rst, Mode_active);
    end
    H_count = 11'd799;
    V_count = 11'd524;
    tick();
    H_count = 11'd0;
    V_count = 11'd0;
    checks++;
    if (H_count_max !== 11'd1343 || V_count_max !== 11'd805 ||
        H_sync_pulse !== 8'd136 || V_sync_pulse !== 8'd6) begin
      errors++;
      $display("FAIL change_params: got %0d/%0d/%0d/%0d want 1343/805/136/6",
               H_count_max, V_count_max, H_sync_pulse, V_sync_pulse);
    end
    count_rst(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL change_settle_len: got %0d want 16", n);
    end
    checks++;
    if (Mode_active !== 2'd2 || Busy !== 1'b0 || Cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL change_done: got mode=%0d busy=%b rdy=%b want 2 0 1",
               Mode_active, Busy, Cfg_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    apply_reset();
    count_rst(n);
    Cfg_valid = 1'b1;
    Cfg_mode  = 2'd1;
    tick();
    Cfg_valid = 1'b0;
    H_count   = 11'd799;
    V_count   = 11'd524;
    tick();
    H_count = 11'd0;
    V_count = 11'd0;
    checks++;
    if (Mode_active !== 2'd1 || H_count_max !== 11'd1055 || Counter_rst !== 1'b1) begin
      errors++;
      $display("FAIL midload_enter: got mode=%0d max=%0d crst=%b want 1 1055 1",
               Mode_active, H_count_max, Counter_rst);
    end
    for (int i = 0; i < 5; i++) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++;
    if (Mode_active !== 2'd0 || H_count_max !== 11'd799 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL midload_reset: got mode=%0d max=%0d busy=%b want 0 799 1",
               Mode_active, H_count_max, Busy);
    end
    count_rst(n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL midload_settle_len: got %0d want 16", n);
    end
    checks++;
    if (Busy !== 1'b0 || Mode_active !== 2'd0) begin
      errors++;
      $display("FAIL midload_dropped: got busy=%b mode=%0d want 0 0", Busy, Mode_active);
    end
  endtask

  task automatic test_coincident();
    H_count   = 11'd799;
    V_count   = 11'd524;
    Cfg_valid = 1'b1;
    Cfg_mode  = 2'd3;
    tick();
    Cfg_valid = 1'b0;
    H_count   = 11'd0;
    V_count   = 11'd0;
    checks++;
    if (Counter_rst !== 1'b0 || Busy !== 1'b1 || Mode_active !== 2'd0 ||
        H_count_max !== 11'd799) begin
      errors++;
      $display("FAIL coincident_deferred: got crst=%b busy=%b mode=%0d max=%0d want 0 1 0 799",
               Counter_rst, Busy, Mode_active, H_count_max);
    end
    tick();
    tick();
    H_count = 11'd799;
    V_count = 11'd524;
    tick();
    H_count = 11'd0;
    V_count = 11'd0;
    checks++;
    if (H_count_max !== 11'd1687 || V_count_max !== 11'd1065 || Mode_active !== 2'd3 ||
        Counter_rst !== 1'b1) begin
      errors++;
      $display("FAIL coincident_applied: got max=%0d/%0d mode=%0d crst=%b want 1687/1065 3 1",
               H_count_max, V_count_max, Mode_active, Counter_rst);
    end
  endtask

  initial begin
    Rst       = 1'b1;
    Cfg_valid = 1'b0;
    Cfg_mode  = 2'd0;
    H_count   = 11'd0;
    V_count   = 11'd0;
    test_reset();
    test_same_mode();
    test_video();
    test_mode_change();
    test_reset_mid_load();
    test_coincident();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
